// File: rtl/fractal_colorizer.sv
// fractal_colorizer
//
// Turns a stream of Mandelbrot/Julia iteration counts into 24-bit RGB pixels
// and buffers them in a first-word-fall-through FIFO towards an AXI-Stream sink.
//
//   Pipeline: stage 1 registers the input, stage 2 holds the computed colour,
//   and the stage-2 pixel is offered to the FIFO on the following edge.
//   Latency from s_valid sampled to m_axis_tvalid (FIFO empty) is 2 cycles.
//
//   The upstream generator cannot be stalled. When the buffer fills, a
//   frame-sync FSM throws away the rest of the current frame and only restarts
//   writing at the next frame-start pixel. This ensures that the sink never
//   sees a frame with a hole in it.
//
// Parameters
//   FIFO_DEPTH      output buffer depth in pixels; power of 2 in 4..256
//
// Ports
//   clk             single clock
//   resetn          asynchronous active-low reset
//   s_data[7:0]     iteration count
//   s_user          frame start
//   s_last          line end
//   s_valid         pixel qualifier (no upstream ready)
//   m_axis_tdata    RGB pixel: R [23:16], G [15:8], B [7:0]
//   m_axis_tuser    frame start
//   m_axis_tlast    line end
//   m_axis_tvalid   output valid
//   m_axis_tready   downstream ready
//   overflow        sticky: a pixel was lost to a full buffer
//   fifo_level      buffer occupancy, 0..FIFO_DEPTH
//   drop_count      saturating count of pixels discarded after sync was
//                   achieved (present only when COLORIZER_DROP_COUNT_EN is
//                   defined)
//
// Build option
//   COLORIZER_DROP_COUNT_EN  adds the drop_count output and its counter.

module fractal_colorizer #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [7:0]                  s_data,
   input  logic                        s_user,
   input  logic                        s_last,
   input  logic                        s_valid,
   output logic [23:0]                 m_axis_tdata,
   output logic                        m_axis_tuser,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef COLORIZER_DROP_COUNT_EN
   ,
   output logic [31:0]                 drop_count
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   // FIFO word layout: {rgb[23:0], user, last}
   localparam int unsigned FW = 26;

   typedef enum logic [1:0] {
      StSync,
      StRun,
      StDrop
   } state_e;

   // ------------------------------------------------------------------
   // Colour mapping
   // ------------------------------------------------------------------
   function automatic logic [23:0] map_color(input logic [7:0] iter);
      logic [7:0] green;
      green = {iter[6:0], 1'b0} + iter;  // 3*i, wraps mod 256
      if (iter == 8'hFF) begin
         return 24'h000000;              // points inside the set are black
      end
      return {iter, green, ~iter};       // ~i == 255 - i
   endfunction

   // ------------------------------------------------------------------
   // Stage 1: input register
   // ------------------------------------------------------------------
   logic       s1_valid_q;
   logic [7:0] s1_data_q;
   logic       s1_user_q;
   logic       s1_last_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_user_q  <= 1'b0;
         s1_last_q  <= 1'b0;
      end else begin
         s1_valid_q <= s_valid;
         s1_data_q  <= s_data;
         s1_user_q  <= s_user;
         s1_last_q  <= s_last;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: colour register
   // ------------------------------------------------------------------
   logic        s2_valid_q;
   logic [23:0] s2_rgb_q;
   logic        s2_user_q;
   logic        s2_last_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid_q <= 1'b0;
         s2_rgb_q   <= '0;
         s2_user_q  <= 1'b0;
         s2_last_q  <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid_q;
         s2_rgb_q   <= map_color(s1_data_q);
         s2_user_q  <= s1_user_q;
         s2_last_q  <= s1_last_q;
      end
   end

   // ------------------------------------------------------------------
   // FIFO bookkeeping
   // ------------------------------------------------------------------
   logic [LW-1:0] level_q, level_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic          full;
   logic          pop;
   logic          wr_en;

   // Fullness is judged on the occupancy before this cycle's pop, so a
   // write into a full buffer is refused even if a slot frees up now.
   assign full = (level_q == LW'(FIFO_DEPTH));
   assign pop  = m_axis_tvalid && m_axis_tready;

   // ------------------------------------------------------------------
   // Frame-sync FSM, evaluated on the pixel leaving stage 2
   // ------------------------------------------------------------------
   state_e state_q, state_d;
   logic   ovf_set;
   logic   discard_cnt;

   always_comb begin
      state_d     = state_q;
      wr_en       = 1'b0;
      ovf_set     = 1'b0;
      discard_cnt = 1'b0;
      if (s2_valid_q) begin
         case (state_q)
            // Waiting for the first frame start after reset; these
            // discards are expected and not counted.
            StSync: begin
               if (s2_user_q && !full) begin
                  wr_en   = 1'b1;
                  state_d = StRun;
               end
            end
            StRun: begin
               if (full) begin
                  ovf_set     = 1'b1;
                  discard_cnt = 1'b1;
                  state_d     = StDrop;
               end else begin
                  wr_en = 1'b1;
               end
            end
            // Rest of the broken frame is thrown away; resume only on a
            // frame start that actually fits.
            StDrop: begin
               if (s2_user_q && !full) begin
                  wr_en   = 1'b1;
                  state_d = StRun;
               end else begin
                  discard_cnt = 1'b1;
               end
            end
            default: begin
               state_d = StSync;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StSync;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Occupancy and pointers
   // ------------------------------------------------------------------
   always_comb begin
      level_d = level_q;
      if (wr_en && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!wr_en && pop) begin
         level_d = level_q - LW'(1);
      end
   end

   // Pointers are AW bits wide, so incrementing wraps modulo FIFO_DEPTH.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         level_q <= level_d;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Storage (no reset: contents are only visible through level_q)
   // ------------------------------------------------------------------
   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [FW-1:0] rd_word;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= {s2_rgb_q, s2_user_q, s2_last_q};
      end
   end

   assign rd_word = mem[rd_ptr_q];

   // ------------------------------------------------------------------
   // Outputs: first-word-fall-through. Payload is gated by tvalid so the
   // outputs read as zero while the buffer is empty, including in reset.
   // ------------------------------------------------------------------
   assign m_axis_tvalid = (level_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? rd_word[FW-1:2] : '0;
   assign m_axis_tuser  = m_axis_tvalid & rd_word[1];
   assign m_axis_tlast  = m_axis_tvalid & rd_word[0];
   assign fifo_level    = level_q;

   // ------------------------------------------------------------------
   // Sticky overflow
   // ------------------------------------------------------------------
   logic overflow_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow_q <= 1'b0;
      end else if (ovf_set) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

   // ------------------------------------------------------------------
   // Optional dropped-pixel counter
   // ------------------------------------------------------------------
`ifdef COLORIZER_DROP_COUNT_EN
   logic [31:0] drop_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_cnt_q <= '0;
      end else if (discard_cnt && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_q <= drop_cnt_q + 32'd1;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   logic unused_discard_cnt;
   assign unused_discard_cnt = discard_cnt;
`endif

endmodule

// File: tb/tb_fractal_colorizer.sv
// Testbench for fractal_colorizer.
// A queue-based model tracks what the output buffer must contain; a compare
// process checks every output against it each cycle. Directed scenarios add
// hand-computed literal expectations.

module tb_fractal_colorizer;

   localparam int FIFO_DEPTH = 16;

   logic                        clk = 1'b0;
   logic                        resetn = 1'b1;
   logic [7:0]                  s_data = '0;
   logic                        s_user = 1'b0;
   logic                        s_last = 1'b0;
   logic                        s_valid = 1'b0;
   logic [23:0]                 m_axis_tdata;
   logic                        m_axis_tuser;
   logic                        m_axis_tlast;
   logic                        m_axis_tvalid;
   logic                        m_axis_tready = 1'b1;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef COLORIZER_DROP_COUNT_EN
   logic [31:0]                 drop_count;
`endif

   fractal_colorizer #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_data        (s_data),
      .s_user        (s_user),
      .s_last        (s_last),
      .s_valid       (s_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .overflow      (overflow),
      .fifo_level    (fifo_level)
`ifdef COLORIZER_DROP_COUNT_EN
      ,
      .drop_count    (drop_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Model: expected buffer contents plus a 2-deep input delay line
   // ------------------------------------------------------------------
   logic [25:0] exp_q[$];
   bit          p1_v, p2_v;
   logic [7:0]  p1_d, p2_d;
   bit          p1_u, p2_u, p1_l, p2_l;
   bit          m_locked;   // writing frames
   bit          m_ovf;
   int unsigned m_drops;

   function automatic logic [23:0] exp_color(input int i);
      if (i == 255) return 24'h000000;
      return {8'(i), 8'((3 * i) % 256), 8'(255 - i)};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      p1_v = 0; p2_v = 0;
      m_locked = 0;
      m_ovf = 0;
      m_drops = 0;
   endtask

   // One active clock edge with the given inputs and tready.
   task automatic model_edge(input bit v, input logic [7:0] d, input bit u, input bit l,
                             input bit rdy);
      bit full, pop, wr;
      full = (exp_q.size() == FIFO_DEPTH);
      pop  = (exp_q.size() != 0) && rdy;
      wr   = 0;
      if (p2_v) begin
         if (!m_locked) begin
            if (p2_u && !full) begin
               wr = 1;
               m_locked = 1;
            end else if (m_ovf) begin
               m_drops++;   // only discards after a lost pixel are counted
            end
         end else if (full) begin
            m_ovf = 1;
            m_locked = 0;
            m_drops++;
         end else begin
            wr = 1;
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (wr) exp_q.push_back({exp_color(int'(p2_d)), p2_u, p2_l});
      p2_v = p1_v; p2_d = p1_d; p2_u = p1_u; p2_l = p1_l;
      p1_v = v;    p1_d = d;    p1_u = u;    p1_l = l;
   endtask

   // ------------------------------------------------------------------
   // Per-cycle compare against the model
   // ------------------------------------------------------------------
   always begin
      logic [25:0] w;
      @(negedge clk);
      #1;
      if (resetn) begin
         check("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
         check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
         check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef COLORIZER_DROP_COUNT_EN
         check("drop_count", drop_count, m_drops);
`endif
         if (exp_q.size() != 0) begin
            w = exp_q[0];
            check("tdata", 32'(m_axis_tdata), 32'(w[25:2]));
            check("tuser", 32'(m_axis_tuser), 32'(w[1]));
            check("tlast", 32'(m_axis_tlast), 32'(w[0]));
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (called and returning at a falling edge)
   // ------------------------------------------------------------------
   task automatic drive(input bit v, input int d, input bit u, input bit l, input bit rdy);
      s_valid = v;
      s_data = 8'(d);
      s_user = u;
      s_last = l;
      m_axis_tready = rdy;
      @(posedge clk);
      model_edge(v, 8'(d), u, l, rdy);
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      drive(0, 0, 0, 0, rdy);
   endtask

   task automatic do_reset();
      s_valid = 0; s_data = '0; s_user = 0; s_last = 0;
      resetn = 0;
      model_reset();
      #1;
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_tuser", 32'(m_axis_tuser), 32'd0);
      check("rst_tlast", 32'(m_axis_tlast), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Colour mapping, 2-cycle latency
      drive(1, 0, 1, 0, 1);
      check("map_lat0", 32'(m_axis_tvalid), 32'd0);
      drive(1, 1, 0, 0, 1);
      check("map_lat1", 32'(m_axis_tvalid), 32'd0);
      drive(1, 100, 0, 0, 1);
      check("map_p0_valid", 32'(m_axis_tvalid), 32'd1);
      check("map_p0_tdata", 32'(m_axis_tdata), 32'h0000FF);
      check("map_p0_tuser", 32'(m_axis_tuser), 32'd1);
      drive(1, 255, 0, 1, 1);
      check("map_p1_tdata", 32'(m_axis_tdata), 32'h0103FE);
      check("map_p1_tuser", 32'(m_axis_tuser), 32'd0);
      idle(1);
      check("map_p2_tdata", 32'(m_axis_tdata), 32'h642C9B);
      idle(1);
      check("map_p3_tdata", 32'(m_axis_tdata), 32'h000000);
      check("map_p3_tlast", 32'(m_axis_tlast), 32'd1);
      idle(1);

      // SYNC discards pixels until a frame start
      do_reset();
      for (int k = 0; k < 3; k++) drive(1, 5, 0, 0, 1);
      drive(1, 10, 1, 0, 1);
      check("sync_none0", 32'(m_axis_tvalid), 32'd0);
      idle(1);
      check("sync_none1", 32'(m_axis_tvalid), 32'd0);
      idle(1);
      check("sync_first_valid", 32'(m_axis_tvalid), 32'd1);
      check("sync_first_tuser", 32'(m_axis_tuser), 32'd1);
      check("sync_first_tdata", 32'(m_axis_tdata), 32'h0A1EF5);
      idle(1);

      // Backpressure: a full 16-pixel frame waits, then drains in order
      for (int k = 0; k < 16; k++) drive(1, k * 7, k == 0, k == 15, 0);
      idle(0);
      idle(0);
      check("bp_level", 32'(fifo_level), 32'd16);
      check("bp_valid", 32'(m_axis_tvalid), 32'd1);
      check("bp_tdata", 32'(m_axis_tdata), 32'h0000FF);
      for (int k = 0; k < 3; k++) idle(0);
      check("bp_stable_tdata", 32'(m_axis_tdata), 32'h0000FF);
      check("bp_stable_tuser", 32'(m_axis_tuser), 32'd1);
      check("bp_overflow", 32'(overflow), 32'd0);
      for (int k = 0; k < 16; k++) idle(1);
      check("bp_drained", 32'(fifo_level), 32'd0);

      // Overflow: 20 pixels into 16 slots
      do_reset();
      for (int k = 0; k < 20; k++) drive(1, 200 + k, k == 0, k == 19, 0);
      idle(0);
      idle(0);
      check("ovf_level", 32'(fifo_level), 32'd16);
      check("ovf_flag", 32'(overflow), 32'd1);
`ifdef COLORIZER_DROP_COUNT_EN
      check("ovf_drops", drop_count, 32'd4);
`endif
      for (int k = 0; k < 3; k++) drive(1, 40 + k, 0, 0, 0);
      idle(0);
      idle(0);
      for (int k = 0; k < 16; k++) idle(1);
      check("ovf_drained", 32'(fifo_level), 32'd0);
      drive(1, 60, 0, 0, 1);
      drive(1, 33, 1, 1, 1);
      idle(1);
      check("ovf_still_dropping", 32'(m_axis_tvalid), 32'd0);
      idle(1);
      check("ovf_resume_valid", 32'(m_axis_tvalid), 32'd1);
      check("ovf_resume_tuser", 32'(m_axis_tuser), 32'd1);
      check("ovf_resume_tdata", 32'(m_axis_tdata), 32'h2163DE);
      check("ovf_sticky", 32'(overflow), 32'd1);
      idle(1);

      // Full buffer with a pop in the same cycle: write is still refused
      do_reset();
      for (int k = 0; k < 17; k++) drive(1, k, k == 0, 0, 0);
      idle(0);
      check("edge_level_full", 32'(fifo_level), 32'd16);
      check("edge_no_ovf_yet", 32'(overflow), 32'd0);
      idle(1);
      check("edge_level", 32'(fifo_level), 32'd15);
      check("edge_ovf", 32'(overflow), 32'd1);
      check("edge_next_tdata", 32'(m_axis_tdata), 32'h0103FE);

      // Reset mid-operation with 8 pixels buffered
      for (int k = 0; k < 15; k++) idle(1);
      for (int k = 0; k < 8; k++) drive(1, 50 + k, k == 0, k == 7, 0);
      idle(0);
      idle(0);
      check("mid_level", 32'(fifo_level), 32'd8);
      check("mid_ovf", 32'(overflow), 32'd1);
      do_reset();
      drive(1, 9, 0, 0, 1);
      drive(1, 77, 1, 0, 1);
      idle(1);
      check("mid_post_empty", 32'(m_axis_tvalid), 32'd0);
      idle(1);
      check("mid_post_valid", 32'(m_axis_tvalid), 32'd1);
      check("mid_post_tuser", 32'(m_axis_tuser), 32'd1);
      check("mid_post_tdata", 32'(m_axis_tdata), 32'h4DE7B2);
      idle(1);
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fractal_colorizer.md
FRACTAL_COLORIZER -- requirements
Module: fractal_colorizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, giving the output buffer depth in pixels; power of 2, range 4..256.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- s_data  in  8  iteration count from the generator.
- s_user  in  1  frame start.
- s_last  in  1  line end.
- s_valid  in  1  pixel qualifier; there is no upstream ready.
- m_axis_tdata  out  24  RGB pixel, R in [23:16], G in [15:8], B in [7:0].
- m_axis_tuser  out  1  frame start.
- m_axis_tlast  out  1  line end.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- overflow  out  1  sticky flag: a pixel was lost to a full buffer.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-003 SHALL map iteration count i to colour:
- i==255 gives 0x000000.
- Otherwise R=i, G=(3*i) mod 256, B=255-i, all unsigned 8-bit.
REQ-004 SHALL carry s_user and s_last unchanged alongside each pixel's colour.
REQ-005 SHALL register the input in stage 1, compute the colour in stage 2, then write to the FIFO.
REQ-006 SHALL present the FIFO as first-word-fall-through.
REQ-007 SHALL, with the FIFO empty and tready=1, assert m_axis_tvalid 2 cycles after s_valid is sampled.
REQ-008 SHALL pop one entry per cycle when m_axis_tvalid && m_axis_tready.
REQ-009 SHALL hold m_axis_tdata, tuser and tlast stable while tvalid=1 and tready=0.
REQ-010 SHALL define full as fifo_level==FIFO_DEPTH at the write cycle; a write into a full FIFO is rejected even if a pop happens in the same cycle.
REQ-011 SHALL, on a simultaneous accepted write and pop, leave fifo_level unchanged.
REQ-012 SHALL implement frame-sync FSM with states SYNC, RUN and DROP, evaluated on pixels leaving stage 2:
- SYNC: discard the pixel unless s_user=1; on s_user=1 write it and go to RUN.
- RUN: write the pixel; if the FIFO is full, discard it, set overflow and go to DROP.
- DROP: discard until a pixel with s_user=1; if that pixel is written, go to RUN; if the FIFO is full, stay in DROP.
REQ-013 SHALL never emit a partial frame except a frame already buffered when overflow occurred; the stream resumes only at a frame start.
REQ-014 SHALL make overflow sticky; only reset clears it.
REQ-015 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-016 SHALL, while resetn=0, asynchronously force:
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0;
- overflow=0, fifo_level=0;
- FSM to SYNC, both pipeline stage valids to 0.
REQ-017 SHALL, on reset mid-frame, flush buffered and in-flight pixels; output resumes only at the next s_user pixel.
REQ-018 SHALL release reset synchronously to clk; the first valid pixel may be sampled on the first edge after deassertion.

Configuration
REQ-019 SHALL use macro COLORIZER_DROP_COUNT_EN to control a dropped-pixel counter:
- Defined: adds output drop_count (32 bits, reset 0). It increments once per pixel discarded in RUN or DROP (not SYNC) and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Verification
REQ-020 SHALL cover mapping: frame of 4 pixels, i=0,1,100,255, tready=1 -> tdata 0x0000FF, 0x0103FE, 0x642C9B, 0x000000; tuser on the first, tlast per input; each appears 2 cycles after its input.
REQ-021 SHALL cover SYNC discard: after reset, 3 pixels with s_user=0, then a pixel with s_user=1 -> no output for the first 3; output starts with the s_user pixel, tuser=1.
REQ-022 SHALL cover backpressure: FIFO_DEPTH=16, tready=0, a 16-pixel frame -> fifo_level=16, tvalid=1 with data stable; tready=1 -> all 16 pixels out in order, level 0.
REQ-023 SHALL cover overflow: FIFO_DEPTH=16, tready=0, 20 pixels -> 16 buffered, overflow=1, drop_count=4 when enabled; further s_user=0 pixels dropped; after draining, the next s_user pixel is accepted.
REQ-024 SHALL cover the full-with-pop edge: level=16, a pop and a write in the same cycle -> write rejected, level=15, overflow=1.
REQ-025 SHALL cover reset mid-operation: resetn low for 1 cycle with level=8 -> all outputs 0 immediately; the next output is the next frame-start pixel.
